// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker family.
// Packed vector layout is {a, b, cin, sum, cout}, MSB first.
package fa_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int FA_VEC_W     = 5;
    localparam int VEC_A_BIT    = 4;
    localparam int VEC_B_BIT    = 3;
    localparam int VEC_CIN_BIT  = 2;
    localparam int VEC_SUM_BIT  = 1;
    localparam int VEC_COUT_BIT = 0;

    // Build a packed {a,b,cin,sum,cout} vector from its fields.
    function automatic logic [FA_VEC_W-1:0] pack_vec(
        input logic a,
        input logic b,
        input logic cin,
        input logic sum,
        input logic cout
    );
        logic [FA_VEC_W-1:0] v;
        v                = {FA_VEC_W{1'b0}};
        v[VEC_A_BIT]     = a;
        v[VEC_B_BIT]     = b;
        v[VEC_CIN_BIT]   = cin;
        v[VEC_SUM_BIT]   = sum;
        v[VEC_COUT_BIT]  = cout;
        return v;
    endfunction

endpackage

// File: rtl/fa_resp_checker_if.sv
// Bus bundle between a full-adder stimulus source (master) and the
// response checker (slave): start/valid handshake, observed adder pins,
// and the checker's result outputs.
interface fa_resp_checker_if
    import fa_chk_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic                start_i;
    logic                valid_i;
    logic                a_i;
    logic                b_i;
    logic                cin_i;
    logic                sum_i;
    logic                cout_i;
    logic                busy_o;
    logic                done_o;
    logic                pass_o;
    logic [CNT_W-1:0]    vec_cnt_o;
    logic [CNT_W-1:0]    err_cnt_o;
    logic [FA_VEC_W-1:0] first_err_o;
    logic [CNT_W-1:0]    first_idx_o;
    logic                first_vld_o;

    modport master (
        output start_i, valid_i, a_i, b_i, cin_i, sum_i, cout_i,
        input  busy_o, done_o, pass_o, vec_cnt_o, err_cnt_o,
               first_err_o, first_idx_o, first_vld_o
    );

    modport slave (
        input  start_i, valid_i, a_i, b_i, cin_i, sum_i, cout_i,
        output busy_o, done_o, pass_o, vec_cnt_o, err_cnt_o,
               first_err_o, first_idx_o, first_vld_o
    );

endinterface

// File: rtl/fa_golden.sv
// Combinational reference full adder, shared by checkers that need a
// golden sum/carry for a given (a, b, cin).
module fa_golden (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic exp_sum_o,
    output logic exp_cout_o
);

    assign exp_sum_o  = a_i ^ b_i ^ cin_i;
    assign exp_cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/fa_resp_checker.sv
// Full-adder response checker: counts N_VEC vectors per run, counts
// mismatches against the golden model (saturating), reports pass/fail.
// Optional first-mismatch capture is built when FA_CHK_FIRST_ERR_EN is
// defined; otherwise first_err_o/first_idx_o/first_vld_o read constant 0.
module fa_resp_checker
    import fa_chk_pkg::*;
#(
    parameter int N_VEC = 10,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fa_resp_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] N_VEC_C = CNT_W'(N_VEC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             exp_sum_s;
    logic             exp_cout_s;
    logic             mismatch_s;

    fa_golden u_golden (
        .a_i        (bus.a_i),
        .b_i        (bus.b_i),
        .cin_i      (bus.cin_i),
        .exp_sum_o  (exp_sum_s),
        .exp_cout_o (exp_cout_s)
    );

    assign mismatch_s = (bus.sum_i != exp_sum_s) || (bus.cout_i != exp_cout_s);

    // Next-state, counter update and registered-output decode.
    always_comb begin
        state_d   = state_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    state_d   = RUN;
                    vec_cnt_d = {CNT_W{1'b0}};
                    err_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d   = state_q;
                end
            end
            RUN: begin
                if (bus.valid_i) begin
                    vec_cnt_d = vec_cnt_q + CNT_ONE;
                    if (mismatch_s && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + CNT_ONE;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if (vec_cnt_d == N_VEC_C) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d   = IDLE;
                vec_cnt_d = {CNT_W{1'b0}};
                err_cnt_d = {CNT_W{1'b0}};
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_cnt_d == {CNT_W{1'b0}});
    end

    // State, counters and status flags, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_cnt_q <= {CNT_W{1'b0}};
            err_cnt_q <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.pass_o    = pass_q;
    assign bus.vec_cnt_o = vec_cnt_q;
    assign bus.err_cnt_o = err_cnt_q;

`ifdef FA_CHK_FIRST_ERR_EN
    logic                cap_clear_s;
    logic                cap_accept_s;
    logic                first_vld_q, first_vld_d;
    logic [FA_VEC_W-1:0] first_err_q, first_err_d;
    logic [CNT_W-1:0]    first_idx_q, first_idx_d;

    assign cap_clear_s  = ((state_q == IDLE) || (state_q == DONE)) && bus.start_i;
    assign cap_accept_s = (state_q == RUN) && bus.valid_i;

    // Capture only the first mismatch of a run; a new start clears it.
    always_comb begin
        first_vld_d = first_vld_q;
        first_err_d = first_err_q;
        first_idx_d = first_idx_q;
        if (cap_clear_s) begin
            first_vld_d = 1'b0;
            first_err_d = {FA_VEC_W{1'b0}};
            first_idx_d = {CNT_W{1'b0}};
        end else if (cap_accept_s && mismatch_s && !first_vld_q) begin
            first_vld_d = 1'b1;
            first_err_d = pack_vec(bus.a_i, bus.b_i, bus.cin_i, bus.sum_i, bus.cout_i);
            first_idx_d = vec_cnt_q;
        end else begin
            first_vld_d = first_vld_q;
        end
    end

    // First-mismatch capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_vld_q <= 1'b0;
            first_err_q <= {FA_VEC_W{1'b0}};
            first_idx_q <= {CNT_W{1'b0}};
        end else begin
            first_vld_q <= first_vld_d;
            first_err_q <= first_err_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign bus.first_vld_o = first_vld_q;
    assign bus.first_err_o = first_err_q;
    assign bus.first_idx_o = first_idx_q;
`else
    assign bus.first_vld_o = 1'b0;
    assign bus.first_err_o = {FA_VEC_W{1'b0}};
    assign bus.first_idx_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fa_resp_checker.sv
// Scoreboard bench for fa_resp_checker: stimulus pushes expected run
// results; a monitor pops and compares whenever done_o rises.
module tb_fa_resp_checker;

`ifdef FA_CHK_FIRST_ERR_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    fa_resp_checker_if #(.CNT_W(8)) bus ();
    fa_resp_checker_if #(.CNT_W(3)) bus_s ();

    fa_resp_checker #(.N_VEC(10), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fa_resp_checker #(.N_VEC(7), .CNT_W(3)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         which;
        logic [7:0] vec;
        logic [7:0] err;
        logic       pass;
        logic       fvld;
        logic [4:0] ferr;
        logic [7:0] fidx;
    } exp_t;

    exp_t exp_q[$];

    // {a,b,cin,sum,cout}, hand-computed full-adder truth table entries
    logic [4:0] clean_v [10] = '{5'b000_00, 5'b001_10, 5'b010_10, 5'b011_01, 5'b100_10,
                                 5'b101_01, 5'b110_01, 5'b111_11, 5'b000_00, 5'b111_11};
    // index 3: 1+1+0 reported as sum=1,cout=1; index 7: 1+1+1 reported cout=0
    logic [4:0] fault_v [10] = '{5'b000_00, 5'b001_10, 5'b010_10, 5'b11011,  5'b100_10,
                                 5'b101_01, 5'b110_01, 5'b111_10, 5'b000_00, 5'b111_11};
    logic [4:0] sat_v   [10] = '{5'b000_11, 5'b001_01, 5'b010_00, 5'b011_10, 5'b100_11,
                                 5'b101_10, 5'b110_10, 5'b000_00, 5'b000_00, 5'b000_00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_in(input int which, input logic st, input logic vld, input logic [4:0] v);
        if (which == 0) begin
            bus.start_i = st;
            bus.valid_i = vld;
            {bus.a_i, bus.b_i, bus.cin_i, bus.sum_i, bus.cout_i} = v;
        end else begin
            bus_s.start_i = st;
            bus_s.valid_i = vld;
            {bus_s.a_i, bus_s.b_i, bus_s.cin_i, bus_s.sum_i, bus_s.cout_i} = v;
        end
    endtask

    task automatic push_exp(input int which, input logic [7:0] vec, input logic [7:0] err,
                            input logic pass, input logic fvld, input logic [4:0] ferr,
                            input logic [7:0] fidx);
        exp_t e;
        e.which = which; e.vec = vec; e.err = err; e.pass = pass;
        e.fvld = fvld; e.ferr = ferr; e.fidx = fidx;
        exp_q.push_back(e);
    endtask

    // Optional start pulse, then n back-to-back vectors; checks done timing.
    task automatic run_vecs(input int which, input bit do_start, input logic [4:0] vecs [10],
                            input int n);
        if (do_start) begin
            @(negedge clk);
            set_in(which, 1'b1, 1'b0, 5'b00000);
            @(negedge clk);
            set_in(which, 1'b0, 1'b0, 5'b00000);
            chk("busy_after_start", (which == 0) ? bus.busy_o : bus_s.busy_o, 1);
        end
        for (int i = 0; i < n; i++) begin
            set_in(which, 1'b0, 1'b1, vecs[i]);
            if (i == n - 1) chk("done_before_last", (which == 0) ? bus.done_o : bus_s.done_o, 0);
            @(negedge clk);
        end
        set_in(which, 1'b0, 1'b0, 5'b00000);
        chk("done_after_last", (which == 0) ? bus.done_o : bus_s.done_o, 1);
    endtask

    task automatic check_result(input int which);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_done", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_which", which, e.which);
            if (which == 0) begin
                chk("sb_vec_cnt", bus.vec_cnt_o, e.vec);
                chk("sb_err_cnt", bus.err_cnt_o, e.err);
                chk("sb_pass", bus.pass_o, e.pass);
                chk("sb_first_vld", bus.first_vld_o, e.fvld);
                chk("sb_first_err", bus.first_err_o, e.ferr);
                chk("sb_first_idx", bus.first_idx_o, e.fidx);
            end else begin
                chk("sb_s_vec_cnt", bus_s.vec_cnt_o, e.vec);
                chk("sb_s_err_cnt", bus_s.err_cnt_o, e.err);
                chk("sb_s_pass", bus_s.pass_o, e.pass);
                chk("sb_s_first_vld", bus_s.first_vld_o, e.fvld);
                chk("sb_s_first_err", bus_s.first_err_o, e.ferr);
                chk("sb_s_first_idx", bus_s.first_idx_o, e.fidx);
            end
        end
    endtask

    logic done_prev   = 1'b0;
    logic done_s_prev = 1'b0;

    // Monitor: compare against the scoreboard on each rising done_o.
    always @(negedge clk) begin
        if (bus.done_o === 1'b1 && done_prev !== 1'b1) check_result(0);
        if (bus_s.done_o === 1'b1 && done_s_prev !== 1'b1) check_result(1);
        done_prev   <= bus.done_o;
        done_s_prev <= bus_s.done_o;
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, 1'b0, 1'b0, 5'b00000);
        set_in(1, 1'b0, 1'b0, 5'b00000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_pass", bus.pass_o, 0);
        chk("rst_vec_cnt", bus.vec_cnt_o, 0);
        chk("rst_err_cnt", bus.err_cnt_o, 0);
        chk("rst_first_vld", bus.first_vld_o, 0);
        chk("rst_first_err", bus.first_err_o, 0);
        chk("rst_first_idx", bus.first_idx_o, 0);
        chk("rst_s_done", bus_s.done_o, 0);

        // valid without start is ignored in IDLE
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1'b0, 1'b1, fault_v[i + 2]);
            @(negedge clk);
        end
        set_in(0, 1'b0, 1'b0, 5'b00000);
        chk("idle_vec_cnt", bus.vec_cnt_o, 0);
        chk("idle_err_cnt", bus.err_cnt_o, 0);
        chk("idle_busy", bus.busy_o, 0);

        // clean run
        push_exp(0, 8'd10, 8'd0, 1'b1, 1'b0, 5'b00000, 8'd0);
        run_vecs(0, 1'b1, clean_v, 10);

        // injected faults at indices 3 and 7
        push_exp(0, 8'd10, 8'd2, 1'b0, FEN, FEN ? 5'b11011 : 5'b00000, FEN ? 8'd3 : 8'd0);
        run_vecs(0, 1'b1, fault_v, 10);
        chk("done_hold_pass", bus.pass_o, 0);

        // back-to-back: start with a (wrong) vector in DONE; vector is dropped
        @(negedge clk);
        set_in(0, 1'b1, 1'b1, 5'b000_11);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 5'b00000);
        chk("b2b_busy", bus.busy_o, 1);
        chk("b2b_done", bus.done_o, 0);
        chk("b2b_pass", bus.pass_o, 0);
        chk("b2b_vec_cnt", bus.vec_cnt_o, 0);
        chk("b2b_err_cnt", bus.err_cnt_o, 0);
        chk("b2b_first_vld", bus.first_vld_o, 0);
        push_exp(0, 8'd10, 8'd0, 1'b1, 1'b0, 5'b00000, 8'd0);
        run_vecs(0, 1'b0, clean_v, 10);

        // reset mid-run after 4 vectors (one faulty), then a clean run
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 5'b00000);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1'b0, 1'b1, fault_v[i]);
            @(negedge clk);
        end
        set_in(0, 1'b0, 1'b0, 5'b00000);
        chk("mid_vec_cnt", bus.vec_cnt_o, 4);
        chk("mid_err_cnt", bus.err_cnt_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_vec_cnt", bus.vec_cnt_o, 0);
        chk("mid_rst_err_cnt", bus.err_cnt_o, 0);
        chk("mid_rst_first_vld", bus.first_vld_o, 0);
        push_exp(0, 8'd10, 8'd0, 1'b1, 1'b0, 5'b00000, 8'd0);
        run_vecs(0, 1'b1, clean_v, 10);

        // saturation: CNT_W=3, N_VEC=7, every vector wrong
        push_exp(1, 8'd7, 8'd7, 1'b0, FEN, FEN ? 5'b000_11 : 5'b00000, 8'd0);
        run_vecs(1, 1'b1, sat_v, 7);
        @(negedge clk);
        chk("sat_hold_err", bus_s.err_cnt_o, 7);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
